pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/rv32i_types.sv | 30 +++
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/sat_counter32.sv | 23 ++
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I types for the pipeline controller
package rv32i_types;

    typedef logic [4:0] rv32i_reg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BUBBLE   = 2'd2
    } pipe_ctrl_state_t;

    // Pipeline-register enables and bubble flushes as one bundle
    typedef struct packed {
        logic load_pc;
        logic load_if_id;
        logic load_id_ex;
        logic load_ex_mem;
        logic load_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
    } pipe_ctl_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // True when a source register is read and matches a nonzero load destination
    function automatic logic reg_hit(input logic uses, input rv32i_reg src, input rv32i_reg dst);
        return uses && (src == dst) && (dst != rv32i_reg'(0));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - memory status, hazard and pipeline-control bundle
interface pipeline_ctrl_if;
    import rv32i_types::*;

    logic     imem_read;
    logic     imem_resp;
    logic     dmem_read;
    logic     dmem_write;
    logic     dmem_resp;
    logic     ex_mem_read;
    rv32i_reg ex_rd;
    rv32i_reg id_rs1;
    rv32i_reg id_rs2;
    logic     id_uses_rs1;
    logic     id_uses_rs2;
    logic     br_taken;

    logic     load_pc;
    logic     load_if_id;
    logic     load_id_ex;
    logic     load_ex_mem;
    logic     load_mem_wb;
    logic     flush_if_id;
    logic     flush_id_ex;

    modport master (
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        output ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, br_taken,
        input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        input  flush_if_id, flush_id_ex
    );

    modport slave (
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        input  ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, br_taken,
        output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
        output flush_if_id, flush_id_ex
    );

endinterface

// File: rtl/sat_counter32.sv
// rtl/sat_counter32.sv - 32-bit event counter with clear and saturation
module sat_counter32
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic [31:0] cnt
);

    // Clear wins over increment; count sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != CNT_MAX) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - five-stage pipeline stall/flush controller
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    pipeline_ctrl_if.slave    bus,
    input  logic              clr_cnt,
    output pipe_ctrl_state_t  state_out,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
);

    logic             mem_stall;
    logic             load_use;
    logic             do_flush;
    logic             do_bubble;
    pipe_ctl_t        ctl;
    pipe_ctrl_state_t state;

    // A simultaneous imem and dmem wait is still one freeze
    assign mem_stall = (bus.imem_read & ~bus.imem_resp)
                     | ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp);

    // Loads into x0 never create a hazard
    assign load_use = bus.ex_mem_read
                    & (reg_hit(bus.id_uses_rs1, bus.id_rs1, bus.ex_rd)
                     | reg_hit(bus.id_uses_rs2, bus.id_rs2, bus.ex_rd));

    assign do_flush  = ~mem_stall & bus.br_taken;
    assign do_bubble = ~mem_stall & ~bus.br_taken & load_use;

    // Enables and flushes are combinational; everything is held off during reset
    always_comb begin
        ctl = '0;
        if (rst && !mem_stall) begin
            ctl.load_id_ex  = 1'b1;
            ctl.load_ex_mem = 1'b1;
            ctl.load_mem_wb = 1'b1;
            if (bus.br_taken) begin
                ctl.load_pc     = 1'b1;
                ctl.load_if_id  = 1'b1;
                ctl.flush_if_id = 1'b1;
                ctl.flush_id_ex = 1'b1;
            end else if (load_use) begin
                ctl.flush_id_ex = 1'b1;
            end else begin
                ctl.load_pc    = 1'b1;
                ctl.load_if_id = 1'b1;
            end
        end
    end

    assign bus.load_pc     = ctl.load_pc;
    assign bus.load_if_id  = ctl.load_if_id;
    assign bus.load_id_ex  = ctl.load_id_ex;
    assign bus.load_ex_mem = ctl.load_ex_mem;
    assign bus.load_mem_wb = ctl.load_mem_wb;
    assign bus.flush_if_id = ctl.flush_if_id;
    assign bus.flush_id_ex = ctl.flush_id_ex;

    // State records which action the controller took on the last edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else if (mem_stall) begin
            state <= MEM_WAIT;
        end else if (do_bubble) begin
            state <= BUBBLE;
        end else begin
            state <= RUN;
        end
    end

    assign state_out = state;

    sat_counter32 u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (mem_stall),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

    sat_counter32 u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .en  (do_bubble),
        .clr (clr_cnt),
        .cnt (bubble_cnt)
    );

    sat_counter32 u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  (do_flush),
        .clr (clr_cnt),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
    import rv32i_types::*;

    typedef struct packed {
        logic     imem_read;
        logic     imem_resp;
        logic     dmem_read;
        logic     dmem_write;
        logic     dmem_resp;
        logic     ex_mem_read;
        rv32i_reg ex_rd;
        rv32i_reg id_rs1;
        rv32i_reg id_rs2;
        logic     id_uses_rs1;
        logic     id_uses_rs2;
        logic     br_taken;
        logic     clr;
    } stim_t;

    logic             clk;
    logic             rst;
    logic             clr_cnt;
    pipe_ctrl_state_t state_out;
    logic [31:0]      stall_cnt;
    logic [31:0]      bubble_cnt;
    logic [31:0]      flush_cnt;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .clr_cnt    (clr_cnt),
        .state_out  (state_out),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    pipe_ctrl_state_t m_state;
    logic [31:0]      m_stall;
    logic [31:0]      m_bubble;
    logic [31:0]      m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex
    function automatic logic [6:0] ctl_now();
        return {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                bus.load_mem_wb, bus.flush_if_id, bus.flush_id_ex};
    endfunction

    function automatic logic [31:0] bump(input logic [31:0] c, input logic inc, input logic clr);
        if (clr) return 32'd0;
        if (inc && c != 32'hFFFF_FFFF) return c + 32'd1;
        return c;
    endfunction

    // Behavioural reference: classify the cycle, then look up the action table
    task automatic step(input stim_t s, input bit release_rst);
        logic       stall, hazard;
        int         mode;
        logic [6:0] table_ctl [4];
        table_ctl[0] = 7'b0000000;
        table_ctl[1] = 7'b1111111;
        table_ctl[2] = 7'b0011101;
        table_ctl[3] = 7'b1111100;
        @(negedge clk);
        if (release_rst) rst = 1'b1;
        bus.imem_read   = s.imem_read;
        bus.imem_resp   = s.imem_resp;
        bus.dmem_read   = s.dmem_read;
        bus.dmem_write  = s.dmem_write;
        bus.dmem_resp   = s.dmem_resp;
        bus.ex_mem_read = s.ex_mem_read;
        bus.ex_rd       = s.ex_rd;
        bus.id_rs1      = s.id_rs1;
        bus.id_rs2      = s.id_rs2;
        bus.id_uses_rs1 = s.id_uses_rs1;
        bus.id_uses_rs2 = s.id_uses_rs2;
        bus.br_taken    = s.br_taken;
        clr_cnt         = s.clr;
        #1;
        stall  = (s.imem_read && !s.imem_resp) || ((s.dmem_read || s.dmem_write) && !s.dmem_resp);
        hazard = s.ex_mem_read && s.ex_rd != 0 &&
                 ((s.id_uses_rs1 && s.ex_rd == s.id_rs1) || (s.id_uses_rs2 && s.ex_rd == s.id_rs2));
        mode = stall ? 0 : s.br_taken ? 1 : hazard ? 2 : 3;
        chk("ctl", 32'(ctl_now()), 32'(table_ctl[mode]));
        m_state  = (mode == 0) ? MEM_WAIT : (mode == 2) ? BUBBLE : RUN;
        m_stall  = bump(m_stall,  mode == 0, s.clr);
        m_flush  = bump(m_flush,  mode == 1, s.clr);
        m_bubble = bump(m_bubble, mode == 2, s.clr);
        @(posedge clk);
        #1;
        chk("state",      32'(state_out), 32'(m_state));
        chk("stall_cnt",  stall_cnt,  m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);
        chk("flush_cnt",  flush_cnt,  m_flush);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.imem_read   = ($urandom_range(0, 3) == 0);
        s.imem_resp   = 1'($urandom_range(0, 1));
        s.dmem_read   = ($urandom_range(0, 4) == 0);
        s.dmem_write  = ($urandom_range(0, 6) == 0);
        s.dmem_resp   = 1'($urandom_range(0, 1));
        s.ex_mem_read = 1'($urandom_range(0, 1));
        s.ex_rd       = rv32i_reg'($urandom_range(0, 3));
        s.id_rs1      = rv32i_reg'($urandom_range(0, 3));
        s.id_rs2      = rv32i_reg'($urandom_range(0, 3));
        s.id_uses_rs1 = 1'($urandom_range(0, 1));
        s.id_uses_rs2 = 1'($urandom_range(0, 1));
        s.br_taken    = ($urandom_range(0, 4) == 0);
        s.clr         = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t lu;
        rst = 1'b0;
        clr_cnt = 1'b0;
        bus.imem_read = 1'b0;   bus.imem_resp = 1'b0;
        bus.dmem_read = 1'b0;   bus.dmem_write = 1'b0; bus.dmem_resp = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.br_taken = 1'b1;
        m_state = RUN; m_stall = '0; m_bubble = '0; m_flush = '0;

        // Reset state, outputs held off even with a branch requested
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl",    32'(ctl_now()), 32'd0);
        chk("rst_state",  32'(state_out), 32'(RUN));
        chk("rst_stall",  stall_cnt,  32'd0);
        chk("rst_bubble", bubble_cnt, 32'd0);
        chk("rst_flush",  flush_cnt,  32'd0);
        step(idle(), 1'b1);

        // Load-use on rs2
        lu = idle();
        lu.ex_mem_read = 1'b1; lu.ex_rd = 5'd5; lu.id_rs2 = 5'd5; lu.id_uses_rs2 = 1'b1;
        s = idle(); s.clr = 1'b1;
        step(s, 1'b0);
        step(lu, 1'b0);
        chk("lu_ctl",    32'(ctl_now()), 32'(7'b0011101));
        chk("lu_state",  32'(state_out), 32'(BUBBLE));
        chk("lu_bubble", bubble_cnt, 32'd1);

        // x0 guard
        s = lu; s.ex_rd = 5'd0; s.id_rs2 = 5'd0;
        step(s, 1'b0);
        chk("x0_ctl",   32'(ctl_now()), 32'(7'b1111100));
        chk("x0_state", 32'(state_out), 32'(RUN));

        // Branch beats load-use
        s = lu; s.br_taken = 1'b1;
        step(s, 1'b0);
        chk("br_ctl",    32'(ctl_now()), 32'(7'b1111111));
        chk("br_flush",  flush_cnt,  32'd1);
        chk("br_bubble", bubble_cnt, 32'd1);

        // Dmem wait with branch ignored
        s = idle(); s.clr = 1'b1;
        step(s, 1'b0);
        s = idle(); s.dmem_read = 1'b1; s.br_taken = 1'b1;
        repeat (4) step(s, 1'b0);
        chk("dm_stall", stall_cnt, 32'd4);
        s.dmem_resp = 1'b1; s.br_taken = 1'b0;
        step(s, 1'b0);
        chk("dm_state", 32'(state_out), 32'(RUN));

        // Both memories waiting at once
        s = idle(); s.imem_read = 1'b1; s.dmem_write = 1'b1;
        step(s, 1'b0);
        chk("both_stall", stall_cnt, 32'd5);

        // Asynchronous reset in MEM_WAIT, away from any edge
        s = idle(); s.dmem_read = 1'b1;
        step(s, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'(RUN));
        chk("arst_stall", stall_cnt, 32'd0);
        chk("arst_flush", flush_cnt, 32'd0);
        chk("arst_ctl",   32'(ctl_now()), 32'd0);
        bus.br_taken = 1'b1; bus.dmem_read = 1'b0;
        #1;
        chk("arst_ctl_br", 32'(ctl_now()), 32'd0);
        m_state = RUN; m_stall = '0; m_bubble = '0; m_flush = '0;
        step(s, 1'b1);

        // Saturation then clear under stall
        force dut.u_stall_cnt.cnt = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.cnt;
        m_stall = 32'hFFFF_FFFD;
        s = idle(); s.imem_read = 1'b1;
        repeat (3) step(s, 1'b0);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        s.clr = 1'b1;
        step(s, 1'b0);
        chk("sat_clr", stall_cnt, 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 300; i++) begin
            step(rand_stim(), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
